// File: rtl/servo_pwm_capture.sv
// Servo PWM receiver: measures high width and rise-to-rise period in clk cycles,
// flags out-of-range widths and declares a dead input after a counter timeout.
//   state  | meaning
//   S_IDLE | waiting for a first rise, no counting
//   S_HIGH | synced input high, counting
//   S_LOW  | synced input low, counting until the next rise
module servo_pwm_capture #(
    parameter logic [19:0] MIN_WIDTH = 20'd30000,
    parameter logic [19:0] MAX_WIDTH = 20'd60000,
    parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pwm_in,
    output logic [19:0] width,
    output logic [19:0] period,
    output logic        valid,
    output logic        range_err,
    output logic        timeout,
    output logic        locked
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    logic        r_sync1, r_pwm_s, r_pwm_d;
    logic        w_rise, w_fall;
    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [19:0] r_w_tmp, w_w_tmp_nxt;
    logic        r_primed, w_primed_nxt;
    logic [19:0] r_width, w_width_nxt;
    logic [19:0] r_period, w_period_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_range_err, w_range_err_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_locked, w_locked_nxt;
    logic        w_limit;

    assign w_rise    = r_pwm_s & ~r_pwm_d;
    assign w_fall    = ~r_pwm_s & r_pwm_d;
    assign w_cnt_inc = r_cnt + 20'd1;
    // >= rather than == so a fall taken exactly at the limit still times out next cycle
    assign w_limit   = (r_cnt >= TIMEOUT);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_w_tmp_nxt     = r_w_tmp;
        w_primed_nxt    = r_primed;
        w_width_nxt     = r_width;
        w_period_nxt    = r_period;
        w_range_err_nxt = r_range_err;
        w_valid_nxt     = 1'b0;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = 20'd1;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    w_w_tmp_nxt = r_cnt;
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = w_cnt_inc;
                end else if (w_limit) begin
                    w_state_nxt   = S_IDLE;
                    w_primed_nxt  = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = 20'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    if (r_primed) begin
                        w_period_nxt    = r_cnt;
                        w_width_nxt     = r_w_tmp;
                        w_range_err_nxt = (r_w_tmp < MIN_WIDTH) || (r_w_tmp > MAX_WIDTH);
                        w_valid_nxt     = 1'b1;
                    end
                    w_state_nxt  = S_HIGH;
                    w_cnt_nxt    = 20'd1;
                    w_primed_nxt = 1'b1;
                end else if (w_limit) begin
                    w_state_nxt   = S_IDLE;
                    w_primed_nxt  = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = 20'd0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_primed_nxt = 1'b0;
                w_cnt_nxt    = 20'd0;
            end
        endcase
        w_locked_nxt = w_primed_nxt & (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_sync1     <= 1'b0;
            r_pwm_s     <= 1'b0;
            r_pwm_d     <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= 20'd0;
            r_w_tmp     <= 20'd0;
            r_primed    <= 1'b0;
            r_width     <= 20'd0;
            r_period    <= 20'd0;
            r_valid     <= 1'b0;
            r_range_err <= 1'b0;
            r_timeout   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_sync1     <= pwm_in;
            r_pwm_s     <= r_sync1;
            r_pwm_d     <= r_pwm_s;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_w_tmp     <= w_w_tmp_nxt;
            r_primed    <= w_primed_nxt;
            r_width     <= w_width_nxt;
            r_period    <= w_period_nxt;
            r_valid     <= w_valid_nxt;
            r_range_err <= w_range_err_nxt;
            r_timeout   <= w_timeout_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    assign width     = r_width;
    assign period    = r_period;
    assign valid     = r_valid;
    assign range_err = r_range_err;
    assign timeout   = r_timeout;
    assign locked    = r_locked;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture with scaled-down limits (1 ms -> 30 cycles) so every
// scenario, including timeouts, runs in a few tens of thousands of cycles.
module tb_servo_pwm_capture;

    localparam int MIN_W = 30;
    localparam int MAX_W = 60;
    localparam int TO    = 1000;

    typedef struct { int w; int p; bit rerr; } vec_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        pwm_in = 1'b0;
    logic [19:0] width, period;
    logic        valid, range_err, timeout, locked;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_rises = 0;
    int   exp_to = 0;
    int   last_valid_cyc = 0;
    int   held_w = 0, held_p = 0;
    vec_t last_pulse = '{0, 0, 1'b0};
    vec_t sb_q[$];
    vec_t e;
    vec_t vecs[8];

    servo_pwm_capture #(
        .MIN_WIDTH (20'(MIN_W)),
        .MAX_WIDTH (20'(MAX_W)),
        .TIMEOUT   (20'(TO))
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .pwm_in    (pwm_in),
        .width     (width),
        .period    (period),
        .valid     (valid),
        .range_err (range_err),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every rise after the second since IDLE reports the pulse that preceded it.
    task automatic start_rise();
        if (n_rises >= 2) sb_q.push_back(last_pulse);
        n_rises++;
        pwm_in = 1'b1;
    endtask

    task automatic drive_pulse(input int w, input int p, input bit rerr);
        start_rise();
        if (p > TO) exp_to++;
        repeat (w) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - w) @(negedge clk);
        last_pulse = '{w, p, rerr};
        if (p > TO) n_rises = 0;
    endtask

    always @(negedge clk) begin
        if (valid && timeout) check("valid_and_timeout_overlap", 1, 0);
        if (valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("width", width, e.w);
                check("period", period, e.p);
                check("range_err", range_err, e.rerr);
                check("locked_at_valid", locked, 1);
                held_w = e.w;
                held_p = e.p;
                last_valid_cyc = cyc;
            end
        end
        if (timeout) begin
            check("timeout_expected", (exp_to > 0), 1);
            if (exp_to > 0) exp_to--;
            check("timeout_delay", cyc - last_valid_cyc, TO);
            check("width_held", width, held_w);
            check("period_held", period, held_p);
            check("locked_after_timeout", locked, 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{45, 600, 1'b0};
        vecs[1] = '{45, 600, 1'b0};
        vecs[2] = '{20, 600, 1'b1};
        vecs[3] = '{70, 600, 1'b1};
        vecs[4] = '{30, 600, 1'b0};
        vecs[5] = '{60, 600, 1'b0};
        vecs[6] = '{29, 300, 1'b1};
        vecs[7] = '{61, 300, 1'b1};

        // Reset held with the input already high mid-pulse
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_width", width, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_range_err", range_err, 0);
        check("rst_timeout", timeout, 0);
        check("rst_locked", locked, 0);
        clr = 1'b0;
        n_rises = 1;
        repeat (20) @(negedge clk);
        pwm_in = 1'b0;
        repeat (580) @(negedge clk);

        for (int i = 0; i < 8; i++) drive_pulse(vecs[i].w, vecs[i].p, vecs[i].rerr);

        // Stuck low after lock
        drive_pulse(45, TO + 50, 1'b0);
        check("unlocked_idle_low", locked, 0);

        // Re-prime, then stuck high
        drive_pulse(45, 600, 1'b0);
        drive_pulse(45, 600, 1'b0);
        drive_pulse(TO + 50, TO + 100, 1'b0);
        check("unlocked_idle_high", locked, 0);

        // Rise coinciding with the timeout count
        drive_pulse(45, 600, 1'b0);
        drive_pulse(45, 600, 1'b0);
        drive_pulse(45, TO, 1'b0);
        drive_pulse(45, 600, 1'b0);
        drive_pulse(45, 600, 1'b0);

        // clr pulsed in the middle of a high pulse
        start_rise();
        repeat (20) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_width", width, 0);
        check("clr_period", period, 0);
        check("clr_valid", valid, 0);
        check("clr_range_err", range_err, 0);
        check("clr_timeout", timeout, 0);
        check("clr_locked", locked, 0);
        n_rises = 1;
        repeat (25) @(negedge clk);
        pwm_in = 1'b0;
        repeat (555) @(negedge clk);
        drive_pulse(45, 600, 1'b0);
        check("not_relocked_after_two", locked, 1);
        drive_pulse(50, 600, 1'b0);
        drive_pulse(45, 600, 1'b0);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        check("timeouts_all_seen", exp_to, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
